// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM states
// and the request legality check applied at acceptance.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RMW_READ = 3'd2,
    S_WRITE    = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  // True when the request must be answered with resp_err instead of touching RAM.
  function automatic logic req_error(input logic        we,
                                     input logic [2:0]  funct3,
                                     input logic [31:0] addr,
                                     input logic [31:0] capacity);
    logic illegal;
    logic misaligned;
    logic out_of_range;
    if (we) illegal = !(funct3 inside {F3_B, F3_H, F3_W});
    else    illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned = 1'b0;
    case (funct3)
      F3_H, F3_HU: misaligned = addr[0];
      F3_W:        misaligned = |addr[1:0];
      default:     misaligned = 1'b0;
    endcase
    out_of_range = {addr[31:2], 2'b00} > (capacity - 32'd4);
    return illegal | misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus word-aligned RAM port of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_we;

  // The unit itself.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );

  // The core and RAM around it.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/lsu_lane.sv
// Byte/halfword lane handling: load extraction with extension, and sub-word
// merge of store data into a read word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{offset_i, 3'b000} +: 8];
  assign half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    load_o = word_i;
    case (funct3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_o = {24'd0, byte_sel};
      F3_HU:   load_o = {16'd0, half_sel};
      default: load_o = word_i;
    endcase
  end

  always_comb begin
    store_o = word_i;
    case (funct3_i)
      F3_B:    store_o[{offset_i, 3'b000} +: 8]    = wdata_i[7:0];
      F3_H:    store_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: store_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one request at a time, talks to a RAM with
// combinational read / clocked word write, and returns one response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_CAPACITY = 4096
) (
  input logic               m_clock,
  input logic               p_reset,
  load_store_unit_if.slave  bus
);

  localparam logic [31:0] CAPACITY = 32'(MEM_CAPACITY);

  state_t      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] load_data;
  logic [31:0] store_word;

  lsu_lane u_lane (
    .word_i   (bus.mem_rdata),
    .offset_i (offset_q),
    .funct3_i (funct3_q),
    .wdata_i  (wdata_q),
    .load_o   (load_data),
    .store_o  (store_word)
  );

  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    offset_d     = offset_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          funct3_d     = bus.req_funct3;
          offset_d     = bus.req_addr[1:0];
          wdata_d      = bus.req_wdata;
          mem_addr_d   = {bus.req_addr[31:2], 2'b00};
          resp_rdata_d = '0;
          resp_err_d   = req_error(bus.req_we, bus.req_funct3, bus.req_addr, CAPACITY);
          if (resp_err_d) begin
            state_d = S_RESP;
          end else if (!bus.req_we) begin
            state_d = S_LOAD;
          end else if (bus.req_funct3 == F3_W) begin
            mem_wdata_d = bus.req_wdata;
            state_d     = S_WRITE;
          end else begin
            state_d = S_RMW_READ;
          end
        end
      end
      S_LOAD: begin
        resp_rdata_d = load_data;
        state_d      = S_RESP;
      end
      S_RMW_READ: begin
        mem_wdata_d = store_word;
        state_d     = S_WRITE;
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (bus.resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_q      <= S_IDLE;
      funct3_q     <= '0;
      offset_q     <= '0;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      offset_q     <= offset_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  // Gated by reset so a reset landing in WRITE cannot commit a partial store.
  assign bus.mem_we     = (state_q == S_WRITE) && !p_reset;

endmodule
